// File: rtl/osc_pkg.sv
// Shared oscilloscope definitions: frame geometry, reader FSM states and the
// sample-to-pixel scaling used by both the capture side and the plotter.
package osc_pkg;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 12;
  localparam int Y_W    = 8;

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  // Keep the top Y_W bits of the sample (truncation, no rounding) and flip
  // them so that full scale lands on pixel row 0 at the top of the screen.
  function automatic logic [Y_W-1:0] y_map(input logic [DATA_W-1:0] sample);
    logic [Y_W-1:0] top_bits;
    top_bits = sample[DATA_W-1 -: Y_W];
    return {Y_W{1'b1}} - top_bits;
  endfunction

endpackage

// File: rtl/wave_reader_if.sv
// Point stream from the wave reader to the display plotter (valid/ready).
interface wave_reader_if;
  import osc_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_x;
  logic [Y_W-1:0]    out_y;
  logic              out_last;

  modport master (output out_valid, out_x, out_y, out_last, input out_ready);
  modport slave  (input out_valid, out_x, out_y, out_last, output out_ready);

endinterface

// File: rtl/wave_skid_fifo.sv
// Two-entry skid buffer holding already-mapped pixel rows between the sample
// memory read port and the plotter handshake.
module wave_skid_fifo #(
  parameter int WIDTH = osc_pkg::Y_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry_reg [2];
  logic             rd_ptr_reg;
  logic             wr_ptr_reg;
  logic [1:0]       count_reg;
  logic             do_pop;

  assign do_pop = pop && (count_reg != 2'd0);
  assign count  = count_reg;
  assign head   = entry_reg[rd_ptr_reg];

  // Ping-pong storage; a push into a full buffer is legal only alongside a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
    end else begin
      if (push) begin
        entry_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // The reader's read budget must make this impossible; catch it if not.
  overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_reg == 2'd2)));

endmodule

// File: rtl/wave_reader.sv
// Frame readout engine: walks the captured frame oldest-first from the
// trigger pointer, maps each sample to a pixel row and streams (x, y) points
// to the plotter while holding off the capture path.
module wave_reader
  import osc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_done,
  input  logic [ADDR_W-1:0] start_index,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  wave_reader_if.master     plot,
  output logic              busy,
  output logic              hold,
  output logic              overrun
);

  reader_state_t     state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] rc_reg;
  logic [ADDR_W-1:0] oc_reg;
  logic              inflight_reg;
  logic              busy_reg;
  logic              overrun_reg;

  logic [1:0]        fifo_count;
  logic [1:0]        occupancy;
  logic [Y_W-1:0]    fifo_head;
  logic [Y_W-1:0]    mapped_y;
  logic              out_valid;
  logic              pop;

  // Scaling happens on the way into the buffer so entries are pixel-wide.
  assign mapped_y = y_map(rd_data);

  wave_skid_fifo #(.WIDTH(Y_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (mapped_y),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && plot.out_ready;

  // Points held or on their way after this edge; crediting this cycle's pop
  // lets the reader sustain one point per cycle without exceeding two slots.
  assign occupancy = fifo_count + {1'b0, inflight_reg} - {1'b0, pop};
  assign rd_en     = (state_reg == READ) && (occupancy < 2'd2);
  assign rd_addr   = base_reg + rc_reg;

  assign plot.out_valid = out_valid;
  assign plot.out_x     = oc_reg;
  assign plot.out_y     = fifo_head;
  assign plot.out_last  = out_valid && (oc_reg == LAST_INDEX);

  assign busy    = busy_reg;
  assign hold    = busy_reg;
  assign overrun = overrun_reg;

  // Reader FSM with its counters, in-flight tracking and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      rc_reg       <= '0;
      oc_reg       <= '0;
      inflight_reg <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      overrun_reg  <= frame_done && (state_reg != IDLE);
      if (rd_en) begin
        rc_reg <= rc_reg + 1'b1;
      end
      if (pop) begin
        oc_reg <= oc_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (frame_done) begin
            base_reg  <= start_index;
            rc_reg    <= '0;
            oc_reg    <= '0;
            busy_reg  <= 1'b1;
            state_reg <= READ;
          end
        end
        READ: begin
          if (rd_en && (rc_reg == LAST_INDEX)) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (oc_reg == LAST_INDEX)) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_reader.sv
// Bench for wave_reader: a sample memory model, a ready driver, a scoreboard
// monitor for addresses and points, and a directed/random test sequence.
module tb_wave_reader;
  import osc_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_done;
  logic [ADDR_W-1:0] start_index;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              hold;
  logic              overrun;

  wave_reader_if plot ();

  wave_reader dut (
    .clk         (clk),
    .rst         (rst),
    .frame_done  (frame_done),
    .start_index (start_index),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .plot        (plot),
    .busy        (busy),
    .hold        (hold),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int last;
  } point_t;

  point_t exp_q[$];
  int     addr_q[$];
  int     mem [DEPTH];
  int     n_checks = 0;
  int     n_fail = 0;
  int     ready_mode = 1;  // 0: ready low, 1: ready high, 2: random
  int     outstanding = 0;
  bit     mon_rst = 1'b0;
  bit     mon_stalled = 1'b0;
  int     mon_x = 0;
  int     mon_y = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Sample memory: data appears exactly one cycle after the read strobe,
  // garbage otherwise.
  always @(posedge clk) begin
    rd_data <= rd_en ? DATA_W'(mem[rd_addr]) : DATA_W'($urandom);
  end

  // Plotter ready driver.
  initial begin
    plot.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       plot.out_ready = 1'b0;
        1:       plot.out_ready = 1'b1;
        default: plot.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares read addresses and accepted points against the queues.
  initial begin
    forever begin
      @(posedge clk);
      mon_rst = rst;
      @(negedge clk);
      if (mon_rst) begin
        outstanding = 0;
        mon_stalled = 1'b0;
      end else begin
        if (mon_stalled) begin
          check("stall_valid", int'(plot.out_valid), 1);
          check("stall_x", int'(plot.out_x), mon_x);
          check("stall_y", int'(plot.out_y), mon_y);
        end
        if (rd_en) begin
          check("read_expected", int'(addr_q.size() != 0), 1);
          if (addr_q.size() != 0) begin
            int a;
            a = addr_q.pop_front();
            check("rd_addr", int'(rd_addr), a);
          end
          outstanding++;
        end
        if (plot.out_valid && plot.out_ready) begin
          check("point_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            point_t p;
            p = exp_q.pop_front();
            check("out_x", int'(plot.out_x), p.x);
            check("out_y", int'(plot.out_y), p.y);
            check("out_last", int'(plot.out_last), p.last);
            $display("point x=%0d y=%0d last=%0d", plot.out_x, plot.out_y, plot.out_last);
          end
          outstanding--;
        end
        if (rd_en) begin
          check("buffered_le_2", int'(outstanding <= 2), 1);
        end
        mon_stalled = plot.out_valid && !plot.out_ready;
        mon_x = int'(plot.out_x);
        mon_y = int'(plot.out_y);
      end
    end
  end

  task automatic fill_mem(input int ramp);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = ramp ? (i * 16) : int'($urandom_range(0, 4095));
    end
  endtask

  // Pulse frame_done and queue the full expected frame; returns in cycle t.
  task automatic start_frame(input int base);
    @(posedge clk);
    #1;
    start_index = ADDR_W'(base);
    frame_done  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      point_t p;
      int     idx;
      idx    = (base + i) % DEPTH;
      p.x    = i;
      p.y    = (2 ** Y_W - 1) - (mem[idx] >> (DATA_W - Y_W));
      p.last = (i == DEPTH - 1) ? 1 : 0;
      exp_q.push_back(p);
      addr_q.push_back(idx);
    end
    @(posedge clk);
    #1;
    frame_done  = 1'b0;
    start_index = ADDR_W'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, int'(!busy && exp_q.size() == 0 && addr_q.size() == 0), 1);
  endtask

  task automatic wait_point(input int x, input bit need_ready, output bit found);
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge clk);
      if (plot.out_valid && int'(plot.out_x) == x && (!need_ready || plot.out_ready)) begin
        found = 1'b1;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"}, int'(rd_en), 0);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_out_valid"}, int'(plot.out_valid), 0);
    check({tag, "_out_x"}, int'(plot.out_x), 0);
    check({tag, "_out_y"}, int'(plot.out_y), 0);
    check({tag, "_out_last"}, int'(plot.out_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_hold"}, int'(hold), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    int base;
    int stall_reads;

    rst         = 1'b1;
    frame_done  = 1'b0;
    start_index = '0;
    fill_mem(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Ramp frame from base 0 with ready high: latency and end-of-frame timing.
    start_frame(0);
    for (int k = 0; k <= 258; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("first_rd_en", int'(rd_en), 1);
        check("first_rd_addr", int'(rd_addr), 0);
        check("busy_t1", int'(busy), 1);
        check("hold_t1", int'(hold), 1);
      end
      if (k == 1) check("valid_before_latency", int'(plot.out_valid), 0);
      if (k == 2) check("first_valid", int'(plot.out_valid), 1);
      if (k == 256) check("last_early", int'(plot.out_last), 0);
      if (k == 257) begin
        check("last_at_t257", int'(plot.out_last), 1);
        check("busy_at_t257", int'(busy), 1);
      end
      if (k == 258) begin
        check("busy_low_t258", int'(busy), 0);
        check("hold_low_t258", int'(hold), 0);
      end
    end
    wait_idle("ramp");

    // Wrapping base address.
    fill_mem(0);
    start_frame(8'hF0);
    @(negedge clk);
    check("wrap_first_addr", int'(rd_addr), 8'hF0);
    wait_idle("wrap");

    // Ten-cycle stall holding point x=5.
    fill_mem(0);
    ready_mode = 1;
    start_frame(int'($urandom_range(0, DEPTH - 1)));
    wait_point(4, 1'b1, found);
    check("stall_reach_x4", int'(found), 1);
    ready_mode  = 0;
    stall_reads = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold_x5", int'(plot.out_x), 5);
      if (rd_en) stall_reads++;
    end
    check("stall_reads_le_2", int'(stall_reads <= 2), 1);
    ready_mode = 1;
    wait_idle("stall");

    // Random back-pressure over a whole frame.
    fill_mem(0);
    ready_mode = 2;
    start_frame(int'($urandom_range(0, DEPTH - 1)));
    wait_idle("random_ready");

    // frame_done while busy: mid-frame and coincident with the last handshake.
    fill_mem(0);
    base = int'($urandom_range(0, DEPTH - 1));
    start_frame(base);
    wait_point(100, 1'b0, found);
    check("overrun_reach_x100", int'(found), 1);
    frame_done  = 1'b1;
    start_index = ADDR_W'(base ^ 8'h55);
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    @(negedge clk);
    check("overrun_mid_pulse", int'(overrun), 1);
    @(negedge clk);
    check("overrun_mid_clear", int'(overrun), 0);
    ready_mode = 1;
    wait_point(DEPTH - 1, 1'b1, found);
    check("overrun_reach_last", int'(found), 1);
    frame_done = 1'b1;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    @(negedge clk);
    check("overrun_last_pulse", int'(overrun), 1);
    check("overrun_last_idle", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("overrun_no_restart", int'(rd_en || busy), 0);
    end
    wait_idle("overrun");

    // Reset in the middle of a frame with a read in flight.
    fill_mem(0);
    ready_mode = 1;
    start_frame(int'($urandom_range(0, DEPTH - 1)));
    wait_point(50, 1'b1, found);
    check("reset_reach_x50", int'(found), 1);
    check("reset_read_in_flight", int'(rd_en), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    exp_q.delete();
    addr_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_quiet", int'(plot.out_valid || rd_en), 0);
    end
    fill_mem(0);
    ready_mode = 2;
    start_frame(int'($urandom_range(0, DEPTH - 1)));
    wait_idle("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
